decode_stage: RTL and testbench
===============================

# decode_stage

Registered MIPS instruction-decode stage sitting between the fetch buffer and the ID/EX register of the P7 pipeline. It classifies each instruction into a one-hot class vector, raises RI and Syscall exception codes, and tags branch-delay-slot instructions. It buffers up to two decoded instructions with a valid/ready handshake and supports a synchronous flush for eret and exception entry.

## Interface
Parameters:
- `PC_W`, 32: width of the carried PC.
- `ENABLE_MULDIV`, 1: when 0, mult/multu/div/divu/mfhi/mflo/mthi/mtlo decode as reserved (RI).
- `ENABLE_CP0`, 1: when 0, mfc0/mtc0/eret decode as RI; syscall is unaffected.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards buffered and incoming instructions.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: instruction address.
- `in_exc` in 5: fetch ExcCode; 0 = none, otherwise AdEL (4).
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream consumes the head.
- `out_instr` out 32, `out_pc` out PC_W: head instruction and PC.
- `out_cls` out NUM_CLS: one-hot class of the head.
- `out_exc` out 5: final ExcCode of the head.
- `out_bd` out 1: head sits in a branch delay slot.

## Operation
- Classes (index order): ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, JR, MULDIV, HILO, MFC0, MTC0, ERET, SYSCALL, NOP, RSVD. Exactly one bit is set for a valid head.
- Class mapping:
  - ALU_R: add/sub/and/or/slt/sltu.
  - ALU_I: ori/addi/andi/lui.
  - LOAD: lw/lh/lb. STORE: sw/sh/sb.
  - BRANCH: beq/bne. JUMP: j/jal. JR: jr.
  - MULDIV: mult/multu/div/divu. HILO: mfhi/mflo/mthi/mtlo.
  - MFC0: opcode 010000 with rs = 00000. MTC0: opcode 010000 with rs = 00100. ERET: opcode 010000 with funct = 011000.
  - NOP: instr == 0 exactly. Anything else, including SPECIAL with funct 0 and a nonzero word, is RSVD.
- Exception priority:
  1. A nonzero `in_exc` passes through unchanged; class is still computed.
  2. Otherwise RSVD gives 10 (RI).
  3. Otherwise SYSCALL gives 8.
  4. Otherwise 0.
- Delay-slot tracking:
  - Register `prev_cti` is set on acceptance of a BRANCH, JUMP or JR instruction. It is cleared on acceptance of any other instruction and on flush.
  - `out_bd` records the value of `prev_cti` at the moment that entry was accepted.
  - ERET has no delay slot and clears `prev_cti`.
- Buffer:
  - 2-entry FIFO with a count of 0, 1 or 2. Classification and exception code are computed combinationally at input and stored alongside the entry.
  - Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
  - `in_ready = (count != 2) & ~flush`, a function of registered state plus flush only.
  - `out_valid = (count != 0)`. Head fields come straight from registers.

## Timing
- Reset (async, `reset_n` = 0):
  - count = 0, so `out_valid` = 0 and `in_ready` = 1 once reset is released.
  - `out_instr`, `out_pc`, `out_cls`, `out_exc` = 0; `out_bd` = 0; `prev_cti` = 0.
- Latency: an instruction accepted at edge N is presented with `out_valid` = 1 after edge N. Sustained throughput is 1 instruction per cycle.
- Count transitions:
  - 0 → 1 on push.
  - 1 → 1 on simultaneous push and pop; 1 → 2 on push only; 1 → 0 on pop only.
  - 2 → 1 on pop. No push is possible at 2.
- Full: at count 2, `in_ready` = 0 and the fetch beat holds. A pop at count 2 does not enable a push in the same cycle.
- Flush: wins over push and pop in the same cycle. Next state is count = 0 and `prev_cti` = 0. Head registers keep their old values but `out_valid` = 0.
- Reset mid-operation: immediate return to the reset state; any in-flight entry is lost.
- Stored fields never change while an entry is held.

## Structure
- Package `decode_pkg`:
  - Opcode/funct/rs constants.
  - Class index localparams and NUM_CLS = 15.
  - ExcCode constants: NONE = 0, ADEL = 4, SYS = 8, RI = 10.
- Sub-module `instr_classifier` (combinational): inputs instr, in_exc and the two enable parameters; outputs cls, exc and is_cti.
- Top level holds the 2-entry storage, count, head/tail pointers and `prev_cti`.

## Test plan
- Reset, then push `addi` 0x20080005 at pc 0x3000 with `out_ready` = 1 → next cycle `out_valid` = 1, ALU_I one-hot, exc 0, bd 0.
- Push `beq` 0x10000003 then `ori` 0x34090001 back-to-back → ori emerges with bd = 1; a following `lw` emerges with bd = 0.
- Hold `out_ready` = 0 and push 3 instructions → `in_ready` drops after 2 accepts; the third is held until the first pop; output order is preserved.
- Push 0xFC000000 → RSVD, exc 10. Push 0x0000000C → SYSCALL, exc 8. Push `lw` with `in_exc` = 4 → exc 4.
- With ENABLE_MULDIV = 0, push `mult` 0x01090018 → RSVD, exc 10. With ENABLE_CP0 = 0, `eret` 0x42000018 → exc 10.
- Count = 2 and `prev_cti` = 1, then assert `flush` together with `in_valid` → next cycle `out_valid` = 0; the next accepted instruction has bd = 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants: opcode/funct/rs encodings, class indices and ExcCodes
// for the P7 decode stage.
package decode_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    localparam logic [4:0] RS_MFC0    = 5'b00000;
    localparam logic [4:0] RS_MTC0    = 5'b00100;

    localparam int NUM_CLS = 15;
    localparam logic [3:0] CLS_ALU_R   = 4'd0;
    localparam logic [3:0] CLS_ALU_I   = 4'd1;
    localparam logic [3:0] CLS_LOAD    = 4'd2;
    localparam logic [3:0] CLS_STORE   = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_JUMP    = 4'd5;
    localparam logic [3:0] CLS_JR      = 4'd6;
    localparam logic [3:0] CLS_MULDIV  = 4'd7;
    localparam logic [3:0] CLS_HILO    = 4'd8;
    localparam logic [3:0] CLS_MFC0    = 4'd9;
    localparam logic [3:0] CLS_MTC0    = 4'd10;
    localparam logic [3:0] CLS_ERET    = 4'd11;
    localparam logic [3:0] CLS_SYSCALL = 4'd12;
    localparam logic [3:0] CLS_NOP     = 4'd13;
    localparam logic [3:0] CLS_RSVD    = 4'd14;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;

endpackage

// File: rtl/decode_stage_classifier.sv
// Combinational instruction classifier: one-hot class, final ExcCode and
// control-transfer flag for a single instruction word.
module instr_classifier
    import decode_pkg::*;
#(
    parameter bit ENABLE_MULDIV = 1'b1,
    parameter bit ENABLE_CP0    = 1'b1
) (
    input  logic [31:0]        instr_i,
    input  logic [4:0]         exc_i,
    output logic [NUM_CLS-1:0] cls_o,
    output logic [4:0]         exc_o,
    output logic               is_cti_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [3:0] idx;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign funct = instr_i[5:0];

    always_comb begin
        idx = CLS_RSVD;
        if (instr_i == 32'd0) begin
            idx = CLS_NOP;
        end else begin
            unique case (op)
                OP_SPECIAL: begin
                    unique case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: idx = CLS_ALU_R;
                        FN_JR:      idx = CLS_JR;
                        FN_SYSCALL: idx = CLS_SYSCALL;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            if (ENABLE_MULDIV) idx = CLS_MULDIV;
                        end
                        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: begin
                            if (ENABLE_MULDIV) idx = CLS_HILO;
                        end
                        default: idx = CLS_RSVD;
                    endcase
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: idx = CLS_ALU_I;
                OP_LW, OP_LH, OP_LB:              idx = CLS_LOAD;
                OP_SW, OP_SH, OP_SB:              idx = CLS_STORE;
                OP_BEQ, OP_BNE:                   idx = CLS_BRANCH;
                OP_J, OP_JAL:                     idx = CLS_JUMP;
                OP_COP0: begin
                    // rs selects mfc0/mtc0 before the eret funct is considered
                    if (ENABLE_CP0) begin
                        if (rs == RS_MFC0)        idx = CLS_MFC0;
                        else if (rs == RS_MTC0)   idx = CLS_MTC0;
                        else if (funct == FN_ERET) idx = CLS_ERET;
                    end
                end
                default: idx = CLS_RSVD;
            endcase
        end
    end

    always_comb begin
        cls_o = {{(NUM_CLS-1){1'b0}}, 1'b1} << idx;
        if (exc_i != EXC_NONE)      exc_o = exc_i;
        else if (idx == CLS_RSVD)   exc_o = EXC_RI;
        else if (idx == CLS_SYSCALL) exc_o = EXC_SYS;
        else                        exc_o = EXC_NONE;
        is_cti_o = (idx == CLS_BRANCH) || (idx == CLS_JUMP) || (idx == CLS_JR);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: classifies incoming instructions and buffers up to two
// decoded entries with valid/ready handshaking and a synchronous flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W          = 32,
    parameter bit ENABLE_MULDIV = 1'b1,
    parameter bit ENABLE_CP0    = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [4:0]         in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [NUM_CLS-1:0] out_cls,
    output logic [4:0]         out_exc,
    output logic               out_bd
);

    logic [31:0]        instr_q [2];
    logic [PC_W-1:0]    pc_q    [2];
    logic [NUM_CLS-1:0] cls_q   [2];
    logic [4:0]         exc_q   [2];
    logic               bd_q    [2];

    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic       prev_cti_q, prev_cti_d;

    logic [NUM_CLS-1:0] dec_cls;
    logic [4:0]         dec_exc;
    logic               dec_cti;
    logic               push, pop;

    instr_classifier #(
        .ENABLE_MULDIV (ENABLE_MULDIV),
        .ENABLE_CP0    (ENABLE_CP0)
    ) u_classifier (
        .instr_i  (in_instr),
        .exc_i    (in_exc),
        .cls_o    (dec_cls),
        .exc_o    (dec_exc),
        .is_cti_o (dec_cti)
    );

    assign in_ready  = (count_q != 2'd2) & ~flush;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        prev_cti_d = prev_cti_q;
        if (flush) begin
            // head stays put so the stale head fields remain visible but invalid
            count_d    = 2'd0;
            tail_d     = head_q;
            prev_cti_d = 1'b0;
        end else begin
            if (pop)  head_d = ~head_q;
            if (push) begin
                tail_d     = ~tail_q;
                prev_cti_d = dec_cti;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            prev_cti_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                cls_q[i]   <= '0;
                exc_q[i]   <= '0;
                bd_q[i]    <= 1'b0;
            end
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            prev_cti_q <= prev_cti_d;
            if (push) begin
                instr_q[tail_q] <= in_instr;
                pc_q[tail_q]    <= in_pc;
                cls_q[tail_q]   <= dec_cls;
                exc_q[tail_q]   <= dec_exc;
                bd_q[tail_q]    <= prev_cti_q;
            end
        end
    end

    assign out_instr = instr_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign out_cls   = cls_q[head_q];
    assign out_exc   = exc_q[head_q];
    assign out_bd    = bd_q[head_q];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (all features / muldiv+cp0 disabled) share
// stimulus and are compared against a pattern-table decoder and queue model.
module tb_decode_stage;

    localparam int C_ALU_R = 0, C_ALU_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
    localparam int C_JUMP = 5, C_JR = 6, C_MULDIV = 7, C_HILO = 8, C_MFC0 = 9;
    localparam int C_MTC0 = 10, C_ERET = 11, C_SYSCALL = 12, C_NOP = 13, C_RSVD = 14;
    localparam int NP = 35;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  exc;
        logic        bd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  in_exc;

    logic        ra, va, ba, rb, vb, bb;
    logic [31:0] ia, pa, ib, pb;
    logic [14:0] ca, cb;
    logic [4:0]  ea, eb;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pmask [NP];
    logic [31:0] pmatch[NP];
    int          pcls  [NP];
    bit          pmd   [NP];
    bit          pcp   [NP];
    int          np_fill = 0;

    ent_t qa[$];
    ent_t qb[$];
    bit   preva, prevb;

    always #5 clk = ~clk;

    decode_stage dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ra),
        .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .out_valid(va),
        .out_ready(out_ready), .out_instr(ia), .out_pc(pa), .out_cls(ca), .out_exc(ea),
        .out_bd(ba)
    );

    decode_stage #(.PC_W(32), .ENABLE_MULDIV(1'b0), .ENABLE_CP0(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rb),
        .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .out_valid(vb),
        .out_ready(out_ready), .out_instr(ib), .out_pc(pb), .out_cls(cb), .out_exc(eb),
        .out_bd(bb)
    );

    task automatic add_pat(logic [31:0] m, logic [31:0] v, int c, bit md, bit cp);
        pmask[np_fill]  = m;
        pmatch[np_fill] = v;
        pcls[np_fill]   = c;
        pmd[np_fill]    = md;
        pcp[np_fill]    = cp;
        np_fill++;
    endtask

    function automatic int ref_cls(logic [31:0] w, bit md_en, bit cp_en);
        if (w == 32'd0) return C_NOP;
        for (int i = 0; i < NP; i++) begin
            if ((w & pmask[i]) == pmatch[i]) begin
                if ((pmd[i] && !md_en) || (pcp[i] && !cp_en)) return C_RSVD;
                return pcls[i];
            end
        end
        return C_RSVD;
    endfunction

    function automatic logic [4:0] ref_exc(int c, logic [4:0] fetch_exc);
        if (fetch_exc != 5'd0) return fetch_exc;
        if (c == C_RSVD)       return 5'd10;
        if (c == C_SYSCALL)    return 5'd8;
        return 5'd0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(int k);
        logic        v, r, b;
        logic [31:0] i, p;
        logic [14:0] c, oh;
        logic [4:0]  e;
        ent_t        h;
        int          sz;
        string       s;
        s = (k == 0) ? "a" : "b";
        if (k == 0) begin
            v = va; r = ra; b = ba; i = ia; p = pa; c = ca; e = ea; sz = qa.size();
            if (sz > 0) h = qa[0];
        end else begin
            v = vb; r = rb; b = bb; i = ib; p = pb; c = cb; e = eb; sz = qb.size();
            if (sz > 0) h = qb[0];
        end
        chk({s, ".out_valid"}, v, sz != 0);
        chk({s, ".in_ready"}, r, (sz != 2) && !flush);
        if (sz != 0) begin
            oh = 15'd1 << h.cls;
            chk({s, ".out_instr"}, i, h.instr);
            chk({s, ".out_pc"}, p, h.pc);
            chk({s, ".out_cls"}, c, oh);
            chk({s, ".out_exc"}, e, h.exc);
            chk({s, ".out_bd"}, b, h.bd);
        end
    endtask

    task automatic model_upd(int k);
        ent_t q[$];
        bit   prev, pop, push;
        ent_t n;
        int   c;
        q    = (k == 0) ? qa : qb;
        prev = (k == 0) ? preva : prevb;
        pop  = (q.size() != 0) && out_ready;
        push = in_valid && (q.size() != 2) && !flush;
        if (flush) begin
            q.delete();
            prev = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                c       = ref_cls(in_instr, k == 0, k == 0);
                n.instr = in_instr;
                n.pc    = in_pc;
                n.cls   = 4'(c);
                n.exc   = ref_exc(c, in_exc);
                n.bd    = prev;
                q.push_back(n);
                prev = (c == C_BRANCH) || (c == C_JUMP) || (c == C_JR);
            end
        end
        if (k == 0) begin qa = q; preva = prev; end
        else        begin qb = q; prevb = prev; end
    endtask

    task automatic step(bit iv, logic [31:0] ins, logic [31:0] pc, logic [4:0] ex,
                        bit ordy, bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        in_exc    = ex;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_dut(0);
        check_dut(1);
        model_upd(0);
        model_upd(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        qa.delete(); qb.delete();
        preva = 1'b0; prevb = 1'b0;
        chk("rst.a.valid", va, 1'b0);
        chk("rst.b.valid", vb, 1'b0);
        chk("rst.a.instr", ia, 32'd0);
        chk("rst.a.pc", pa, 32'd0);
        chk("rst.a.cls", ca, 15'd0);
        chk("rst.a.exc", ea, 5'd0);
        chk("rst.a.bd", ba, 1'b0);
        chk("rst.b.cls", cb, 15'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst.a.in_ready", ra, 1'b1);
        chk("rst.b.in_ready", rb, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_exc = '0;

        add_pat(32'hFC00003F, 32'h00000020, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h00000022, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h00000024, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h00000025, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h0000002A, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h0000002B, C_ALU_R, 0, 0);
        add_pat(32'hFC00003F, 32'h00000008, C_JR, 0, 0);
        add_pat(32'hFC00003F, 32'h0000000C, C_SYSCALL, 0, 0);
        add_pat(32'hFC00003F, 32'h00000018, C_MULDIV, 1, 0);
        add_pat(32'hFC00003F, 32'h00000019, C_MULDIV, 1, 0);
        add_pat(32'hFC00003F, 32'h0000001A, C_MULDIV, 1, 0);
        add_pat(32'hFC00003F, 32'h0000001B, C_MULDIV, 1, 0);
        add_pat(32'hFC00003F, 32'h00000010, C_HILO, 1, 0);
        add_pat(32'hFC00003F, 32'h00000011, C_HILO, 1, 0);
        add_pat(32'hFC00003F, 32'h00000012, C_HILO, 1, 0);
        add_pat(32'hFC00003F, 32'h00000013, C_HILO, 1, 0);
        add_pat(32'hFC000000, 32'h20000000, C_ALU_I, 0, 0);
        add_pat(32'hFC000000, 32'h30000000, C_ALU_I, 0, 0);
        add_pat(32'hFC000000, 32'h34000000, C_ALU_I, 0, 0);
        add_pat(32'hFC000000, 32'h3C000000, C_ALU_I, 0, 0);
        add_pat(32'hFC000000, 32'h8C000000, C_LOAD, 0, 0);
        add_pat(32'hFC000000, 32'h84000000, C_LOAD, 0, 0);
        add_pat(32'hFC000000, 32'h80000000, C_LOAD, 0, 0);
        add_pat(32'hFC000000, 32'hAC000000, C_STORE, 0, 0);
        add_pat(32'hFC000000, 32'hA4000000, C_STORE, 0, 0);
        add_pat(32'hFC000000, 32'hA0000000, C_STORE, 0, 0);
        add_pat(32'hFC000000, 32'h10000000, C_BRANCH, 0, 0);
        add_pat(32'hFC000000, 32'h14000000, C_BRANCH, 0, 0);
        add_pat(32'hFC000000, 32'h08000000, C_JUMP, 0, 0);
        add_pat(32'hFC000000, 32'h0C000000, C_JUMP, 0, 0);
        add_pat(32'hFFE00000, 32'h40000000, C_MFC0, 0, 1);
        add_pat(32'hFFE00000, 32'h40800000, C_MTC0, 0, 1);
        add_pat(32'hFC00003F, 32'h40000018, C_ERET, 0, 1);
        add_pat(32'hFFFFFFFF, 32'hFC000000, C_RSVD, 0, 0);
        add_pat(32'hFFFFFFFF, 32'h00000001, C_RSVD, 0, 0);

        do_reset();

        // addi through an empty stage
        step(1, 32'h20080005, 32'h3000, 5'd0, 1, 0);
        step(0, 32'h0, 32'h0, 5'd0, 1, 0);
        drain();

        // beq then ori (delay slot) then lw
        step(1, 32'h10000003, 32'h3004, 5'd0, 1, 0);
        step(1, 32'h34090001, 32'h3008, 5'd0, 1, 0);
        step(1, 32'h8C0A0000, 32'h300C, 5'd0, 1, 0);
        drain();

        // back-pressure: third instruction held until a pop, order preserved
        step(1, 32'h01095020, 32'h4000, 5'd0, 0, 0);
        step(1, 32'h2108FFFF, 32'h4004, 5'd0, 0, 0);
        step(1, 32'hAD090004, 32'h4008, 5'd0, 0, 0);
        step(1, 32'hAD090004, 32'h4008, 5'd0, 0, 0);
        step(1, 32'hAD090004, 32'h4008, 5'd0, 1, 0);
        step(1, 32'hAD090004, 32'h4008, 5'd0, 1, 0);
        drain();

        // exception codes and parameter-disabled opcodes
        step(1, 32'hFC000000, 32'h5000, 5'd0, 1, 0);
        step(1, 32'h0000000C, 32'h5004, 5'd0, 1, 0);
        step(1, 32'h8C080000, 32'h5008, 5'd4, 1, 0);
        step(1, 32'h01090018, 32'h500C, 5'd0, 1, 0);
        step(1, 32'h42000018, 32'h5010, 5'd0, 1, 0);
        step(1, 32'h00000000, 32'h5014, 5'd0, 1, 0);
        step(1, 32'h00001000, 32'h5018, 5'd0, 1, 0);
        drain();

        // full with prev_cti set, then flush alongside in_valid
        step(1, 32'h34090001, 32'h6000, 5'd0, 0, 0);
        step(1, 32'h10000003, 32'h6004, 5'd0, 0, 0);
        step(1, 32'h8C0A0000, 32'h6008, 5'd0, 0, 1);
        step(1, 32'h8C0A0000, 32'h6008, 5'd0, 1, 0);
        drain();

        // reset while entries are held
        step(1, 32'h08000010, 32'h7000, 5'd0, 0, 0);
        step(1, 32'h00000008, 32'h7004, 5'd0, 0, 0);
        do_reset();
        step(1, 32'h3C011234, 32'h7008, 5'd0, 1, 0);
        drain();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            int p, sel;
            sel = int'($urandom_range(0, 9));
            p   = int'($urandom_range(0, NP - 1));
            if (sel == 0)      w = 32'd0;
            else if (sel == 1) w = $urandom;
            else               w = pmatch[p] | ($urandom & ~pmask[p]);
            step($urandom_range(0, 3) != 0, w, $urandom,
                 ($urandom_range(0, 7) == 0) ? 5'd4 : 5'd0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
